// File: rtl/rgb_uart_pkg.sv
// rgb_uart_pkg
// Shared definitions for the RGB status UART path:
//   - ASCII codes used in the status report (colour letters, CR, LF)
//   - state encoding of the report sequencer
//   - default bit period, also used by the UART receiver
//   - rgb_to_ascii(): maps the 3-bit LED drive to its report letter
package rgb_uart_pkg;

    // 50 MHz / 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_G  = 8'h47;
    localparam logic [7:0] ASCII_B  = 8'h42;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_X  = 8'h58;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_CHAR = 2'd1,
        ST_SEND_CR   = 2'd2,
        ST_SEND_LF   = 2'd3
    } tx_state_t;

    // [2]=red, [1]=green, [0]=blue; mixed colours are reported as 'X'
    function automatic logic [7:0] rgb_to_ascii(input logic [2:0] rgb);
        logic [7:0] c;
        case (rgb)
            3'b100:  c = ASCII_R;
            3'b010:  c = ASCII_G;
            3'b001:  c = ASCII_B;
            3'b000:  c = ASCII_O;
            default: c = ASCII_X;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
// Single-byte UART transmitter, 8N1, LSB first, idle high.
// Ports:
//   Clock  in   system clock, rising edge
//   Reset  in   synchronous active-high reset
//   Start  in   begin a frame with Data (accepted when idle or on the Done cycle)
//   Data   in   byte to send, captured when Start is accepted
//   TxD    out  serial line
//   Busy   out  high from the first start-bit cycle through the last stop-bit cycle
//   Done   out  one-cycle pulse during the final cycle of the stop bit
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] Data,
    output logic       TxD,
    output logic       Busy,
    output logic       Done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] clkcnt;
    // 0 = start bit, 1..8 = data bits, 9 = stop bit
    logic [3:0]    bitidx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (clkcnt == LAST_CLK);
    assign Done    = Busy && bit_end && (bitidx == 4'd9);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            TxD    <= 1'b1;
            Busy   <= 1'b0;
            clkcnt <= '0;
            bitidx <= '0;
        end else if (Start && (!Busy || Done)) begin
            // Accepting on the Done cycle chains frames with no idle gap
            TxD    <= 1'b0;
            Busy   <= 1'b1;
            shreg  <= Data;
            clkcnt <= '0;
            bitidx <= '0;
        end else if (Busy) begin
            if (bit_end) begin
                clkcnt <= '0;
                if (bitidx == 4'd9) begin
                    Busy <= 1'b0;
                    TxD  <= 1'b1;
                end else begin
                    bitidx <= bitidx + 4'd1;
                    // Leaving bit k drives data bit k next; leaving d7 drives the stop bit
                    TxD    <= (bitidx == 4'd8) ? 1'b1 : shreg[bitidx[2:0]];
                end
            end else begin
                clkcnt <= clkcnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rgb_status_tx.sv
// rgb_status_tx
// Reports the RGB LED state over UART as "<colour>\r\n" whenever the LED
// drive changes or a query is made. Triggers arriving during a report are
// collapsed into one follow-up report sent back-to-back.
// Ports:
//   Clock  in   system clock, rising edge
//   Reset  in   synchronous active-high reset
//   RGB    in   LED drive [2]=red [1]=green [0]=blue
//   Query  in   one-cycle pulse requesting a report
//   TxD    out  UART serial out, 8N1, idle high
//   Busy   out  high while a report is in flight
import rgb_uart_pkg::*;

module rgb_status_tx #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] RGB,
    input  logic       Query,
    output logic       TxD,
    output logic       Busy
);

    tx_state_t  state;
    logic [2:0] rgb_last;
    logic       pending;
    logic       trig;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;

    assign trig = (RGB != rgb_last) || Query;

    // Start/Data are decoded combinationally from the state so that a
    // trigger puts the start bit on the line on the very next cycle and
    // each following byte begins on the Done cycle of the previous one.
    always_comb begin
        tx_start = 1'b0;
        tx_data  = ASCII_CR;
        case (state)
            ST_IDLE: begin
                tx_start = trig;
                tx_data  = rgb_to_ascii(RGB);
            end
            ST_SEND_CHAR: begin
                tx_start = tx_done;
                tx_data  = ASCII_CR;
            end
            ST_SEND_CR: begin
                tx_start = tx_done;
                tx_data  = ASCII_LF;
            end
            ST_SEND_LF: begin
                tx_start = tx_done && (pending || trig);
                tx_data  = rgb_to_ascii(RGB);
            end
            default: begin
                tx_start = 1'b0;
                tx_data  = ASCII_CR;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        // Tracked through reset so the value present during reset is not reported
        rgb_last <= RGB;
        if (Reset) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trig) state <= ST_SEND_CHAR;
                end
                ST_SEND_CHAR: begin
                    if (trig)    pending <= 1'b1;
                    if (tx_done) state   <= ST_SEND_CR;
                end
                ST_SEND_CR: begin
                    if (trig)    pending <= 1'b1;
                    if (tx_done) state   <= ST_SEND_LF;
                end
                ST_SEND_LF: begin
                    if (tx_done) begin
                        if (pending || trig) begin
                            // The new snapshot already covers this cycle's
                            // trigger unless a pending request is also being
                            // consumed, in which case it is re-armed.
                            state   <= ST_SEND_CHAR;
                            pending <= pending && trig;
                        end else begin
                            state   <= ST_IDLE;
                            pending <= 1'b0;
                        end
                    end else if (trig) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .Clock (Clock),
        .Reset (Reset),
        .Start (tx_start),
        .Data  (tx_data),
        .TxD   (TxD),
        .Busy  (Busy),
        .Done  (tx_done)
    );

endmodule

// File: tb/tb_rgb_status_tx.sv
module tb_rgb_status_tx;

    localparam int CPB = 16;
    localparam int FR  = 10 * CPB;   // cycles per byte frame
    localparam int REP = 3 * FR;     // cycles per report

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rgb;
    logic       query;
    logic       txd;
    logic       busy;

    rgb_status_tx #(.CLKS_PER_BIT(CPB)) dut (
        .Clock (clk),
        .Reset (rst),
        .RGB   (rgb),
        .Query (query),
        .TxD   (txd),
        .Busy  (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] colour(input logic [2:0] v);
        case (v)
            3'b100:  return 8'h52;
            3'b010:  return 8'h47;
            3'b001:  return 8'h42;
            3'b000:  return 8'h4F;
            default: return 8'h58;
        endcase
    endfunction

    // Reference model: reports are intervals of REP cycles on a timeline;
    // line level is derived from position inside the interval.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         cyc = 0;
    bit         m_active = 0;
    bit         m_pending = 0;
    int         m_start = 0;
    logic [2:0] m_last = 3'b000;
    logic [7:0] m_rep[3];
    logic       m_txd = 1'b1;
    logic       m_busy = 1'b0;
    bit         chk_en = 0;

    initial forever begin
        int  p;
        int  bi;
        bit  trig;
        logic [7:0] b;
        @(posedge clk);
        if (m_active && !rst) begin
            p = cyc - m_start;
            if (p % FR == 9 * CPB + CPB / 2) exp_q.push_back(m_rep[p / FR]);
        end
        if (rst) begin
            m_active  = 0;
            m_pending = 0;
        end else begin
            trig = (rgb != m_last) || query;
            if (!m_active || cyc == m_start + REP - 1) begin
                if (!m_active ? trig : (m_pending || trig)) begin
                    if (m_active) m_pending = m_pending && trig;
                    m_active = 1;
                    m_start  = cyc + 1;
                    m_rep[0] = colour(rgb);
                    m_rep[1] = 8'h0D;
                    m_rep[2] = 8'h0A;
                end else begin
                    m_active = 0;
                end
            end else if (trig) begin
                m_pending = 1;
            end
        end
        m_last = rgb;
        if (m_active) begin
            p  = cyc + 1 - m_start;
            bi = (p % FR) / CPB;
            b  = m_rep[p / FR];
            m_txd  = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi - 1];
            m_busy = 1'b1;
        end else begin
            m_txd  = 1'b1;
            m_busy = 1'b0;
        end
        cyc++;
    end

    // Line checks, busy-run tracking and a mid-bit UART decoder
    int   busy_cycles = 0;
    int   run = 0;
    int   last_run = 0;
    bit   dec_active = 0;
    int   dec_cnt = 0;
    logic [7:0] dec_byte;

    initial forever begin
        int k;
        @(negedge clk);
        if (chk_en) begin
            chk("txd", 32'(txd), 32'(m_txd));
            chk("busy", 32'(busy), 32'(m_busy));
        end
        if (busy === 1'b1) begin
            busy_cycles++;
            run++;
        end else if (run > 0) begin
            last_run = run;
            run = 0;
        end
        if (rst) begin
            dec_active = 0;
        end else if (dec_active) begin
            dec_cnt++;
            if (dec_cnt % CPB == CPB / 2) begin
                k = dec_cnt / CPB;
                if (k >= 1 && k <= 8) dec_byte[k - 1] = txd;
                if (k == 9) begin
                    chk("stop_bit", 32'(txd), 32'd1);
                    got_q.push_back(dec_byte);
                    dec_active = 0;
                end
            end
        end else if (txd === 1'b0) begin
            dec_active = 1;
            dec_cnt    = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        step(2);
        while (busy !== 1'b0 && n < 3000) begin
            step(1);
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 32'(busy), 32'd0);
        step(4);
    endtask

    task automatic expect_byte(input string tag, input int back, input logic [7:0] exp);
        if (got_q.size() >= back) chk(tag, 32'(got_q[got_q.size() - back]), 32'(exp));
        else chk({tag, "_len"}, 32'(got_q.size()), 32'(back));
    endtask

    task automatic expect_report(input string tag, input logic [7:0] c);
        expect_byte(tag, 3, c);
        expect_byte(tag, 2, 8'h0D);
        expect_byte(tag, 1, 8'h0A);
    endtask

    initial begin
        int bc;
        int nb;
        rst   = 1'b1;
        rgb   = 3'b100;
        query = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1;
        step(3);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // 1: value held through reset is never reported
        step(2000);
        chk("t1_busy_cycles", 32'(busy_cycles), 32'd0);
        chk("t1_bytes", 32'(got_q.size()), 32'd0);

        // 2: 000 -> 100
        rgb = 3'b000;
        wait_idle();
        expect_report("t2_o", 8'h4F);
        rgb = 3'b100;
        chk("t2_pre_txd", 32'(txd), 32'd1);
        step(1);
        chk("t2_start_bit", 32'(txd), 32'd0);
        chk("t2_busy_on", 32'(busy), 32'd1);
        wait_idle();
        chk("t2_busy_len", 32'(last_run), 32'(REP));
        expect_report("t2_r", 8'h52);

        // 3: queries and the mixed-colour code
        rgb = 3'b010;
        wait_idle();
        expect_report("t3_g_change", 8'h47);
        query = 1'b1; step(1); query = 1'b0;
        wait_idle();
        expect_report("t3_g_query", 8'h47);
        rgb = 3'b011;
        wait_idle();
        expect_report("t3_x_change", 8'h58);
        query = 1'b1; step(1); query = 1'b0;
        wait_idle();
        expect_report("t3_x_query", 8'h58);

        // 4: changes during a report collapse into one follow-up
        nb  = got_q.size();
        rgb = 3'b100;
        step(50);
        rgb = 3'b010;
        step(50);
        rgb = 3'b001;
        wait_idle();
        chk("t4_busy_len", 32'(last_run), 32'(2 * REP));
        chk("t4_nbytes", 32'(got_q.size() - nb), 32'd6);
        expect_byte("t4_first", 6, 8'h52);
        expect_report("t4_second", 8'h42);

        // 5: 001 -> 000
        rgb = 3'b000;
        wait_idle();
        expect_report("t5_o", 8'h4F);

        // 6: reset in the middle of the CR byte
        nb  = got_q.size();
        rgb = 3'b100;
        step(1 + FR + FR / 2);
        rst = 1'b1;
        step(1);
        chk("t6_txd", 32'(txd), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        bc = busy_cycles;
        step(2000);
        chk("t6_quiet", 32'(busy_cycles - bc), 32'd0);
        chk("t6_nbytes", 32'(got_q.size() - nb), 32'd1);
        expect_byte("t6_partial", 1, 8'h52);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 600));
            case ($urandom_range(0, 9))
                0:       begin rst = 1'b1; step($urandom_range(1, 3)); rst = 1'b0; end
                1, 2:    begin query = 1'b1; step(1); query = 1'b0; end
                3:       begin rgb = 3'($urandom); query = 1'b1; step(1); query = 1'b0; end
                default: rgb = 3'($urandom);
            endcase
        end
        wait_idle();

        chk("nbytes", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("byte", 32'(got_q[i]), 32'(exp_q[i]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
